counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
- Front-end controller that drives the program counter's advance/load interface.
- Converts raw panel buttons and switches into clean single-cycle pulses: debounced NEXT, RUN and SPEEDRUN requests, STOP requests, and mode-value loads.
- Contains a run-state machine and tick divider, so the downstream counter only needs a synchronous one-cycle "advance" and "load" strobe.
- Sits between the board I/O pins and the counter, in the same clk domain.

Parameters:
- DEB_CYCLES, 500000, number of consecutive stable samples before a button level is accepted.
- SLOW_DIV, 50000000, clk cycles per advance in RUN (1 s at 50 MHz).
- FAST_DIV, 500000, clk cycles per advance in FAST (10 ms at 50 MHz).
- DIV_W, 26, divider counter width; must hold max(SLOW_DIV, FAST_DIV) - 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_next  in  1  raw single-step button, asynchronous to clk.
- btn_run  in  1  raw run button.
- btn_speedrun  in  1  raw fast-run button.
- btn_stop  in  1  raw stop button.
- sw_mode  in  1  raw switch: 1 = load mode, 0 = step mode.
- sw_value  in  8  raw switch bank; load value.
- halt  in  1  synchronous level from downstream (halt instruction); stops running.
- adv  out  1  one-cycle strobe: counter adds STEP.
- load  out  1  one-cycle strobe: counter loads load_val.
- load_val  out  8  registered value presented with load.
- run_state  out  2  0 = IDLE, 1 = RUN, 2 = FAST; 3 never driven.
- busy  out  1  1 when run_state != IDLE.

Behaviour:
- Reset (rst = 0, asynchronous) clears every flop. adv = 0, load = 0, load_val = 0, run_state = IDLE, busy = 0, divider = 0. All debounced levels are 0, and the edge-detect history is 0.
- Input conditioning:
  - Each of the 5 buttons/switches passes a 2-FF synchronizer, then a debouncer.
  - The debouncer updates its level only after DEB_CYCLES consecutive identical synchronized samples that differ from the current level.
  - sw_value passes a 2-FF synchronizer only (no debounce).
  - Rising edges of debounced buttons form one-cycle request pulses: req_next, req_run, req_fast, req_stop.
- FSM transitions, evaluated each cycle in priority order:
  1. req_stop or halt -> IDLE, divider cleared.
  2. req_fast -> FAST, divider cleared.
  3. req_run -> RUN, divider cleared.
  4. Otherwise hold state.
- FAST -> RUN via req_run is allowed, and vice versa. Re-requesting the current state restarts the divider.
- halt held high keeps the FSM in IDLE, and req_run/req_fast are ignored while halt = 1.
- Divider (RUN/FAST only):
  - Counts 0 .. DIV-1, where DIV = SLOW_DIV in RUN and FAST_DIV in FAST.
  - At terminal count it wraps to 0 and asserts adv for exactly 1 cycle. The first adv occurs DIV cycles after entry.
  - In IDLE the divider is held at 0.
- Single step: req_next in IDLE asserts adv on the following cycle, 1 cycle latency. req_next in RUN/FAST is ignored.
- Load mode:
  - While debounced sw_mode = 1, adv is suppressed in all states.
  - The rising edge of debounced sw_mode, or req_next while sw_mode = 1, asserts load for 1 cycle, with load_val = synchronized sw_value captured in the same cycle.
  - load and adv are never asserted together; load wins.
- Outputs adv, load, load_val and run_state are all registered.
- Reset asserted mid-run returns to IDLE immediately, with no trailing adv.

Test Plan (DEB_CYCLES = 4, SLOW_DIV = 10, FAST_DIV = 3):
- Reset: hold rst = 0 for 5 cycles with all buttons high -> adv = 0, load = 0, run_state = 0; release, then wait 20 cycles with buttons released -> no strobes.
- Debounce and single step: btn_next glitch high for 3 cycles -> no adv; held high for 10 cycles -> exactly one adv, 1 cycle after the debounced edge; held high a further 50 cycles -> no further adv.
- RUN cadence: press btn_run -> run_state = 1, adv every 10 cycles. Press btn_speedrun -> run_state = 2, adv every 3 cycles. Press btn_stop -> run_state = 0, no adv afterwards.
- Halt: in FAST, assert halt for 1 cycle -> run_state = 0 on the next cycle. Press btn_run while halt = 1 -> stays IDLE.
- Load: sw_value = 8'hA5, raise sw_mode -> one load pulse with load_val = 8'hA5. Press btn_next with sw_mode = 1 -> load again, adv = 0. In RUN with sw_mode = 1 -> zero adv over 40 cycles.
- Reset mid-run: in RUN, drop rst when the divider is at 9 -> no adv, run_state = 0, busy = 0 asynchronously.

Source files
------------

// File: rtl/counter_ctrl.sv
// Panel front end for the program counter: synchronizes and debounces buttons, runs the RUN/FAST state machine and tick divider, and issues adv/load strobes.
// Latency: raw button to request = 2 sync + DEB_CYCLES debounce cycles; request to adv/load strobe = 1 cycle (registered outputs).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses, and halt is the only downstream feedback.
module counter_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int SLOW_DIV   = 50000000,
    parameter int FAST_DIV   = 500000,
    parameter int DIV_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_run,
    input  logic       btn_speedrun,
    input  logic       btn_stop,
    input  logic       sw_mode,
    input  logic [7:0] sw_value,
    input  logic       halt,
    output logic       adv,
    output logic       load,
    output logic [7:0] load_val,
    output logic [1:0] run_state,
    output logic       busy
);

    // Conditioned input lanes, in bit order of the raw vector below.
    localparam int NB     = 5;
    localparam int I_NEXT = 0;
    localparam int I_RUN  = 1;
    localparam int I_FAST = 2;
    localparam int I_STOP = 3;
    localparam int I_MODE = 4;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_TC  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] SLOW_TC = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_TC = DIV_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAST = 2'd2
    } state_e;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    meta_q;
    logic [NB-1:0]    sync_q;
    logic [7:0]       val_meta_q;
    logic [7:0]       val_sync_q;
    logic [NB-1:0]    deb_q;
    logic [NB-1:0]    deb_d;
    logic [DEB_W-1:0] cnt_q [NB];
    logic [DEB_W-1:0] cnt_d [NB];
    logic [NB-1:0]    prev_q;
    logic [NB-1:0]    req;

    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_tc;
    logic             tick;
    logic             adv_q;
    logic             adv_d;
    logic             load_q;
    logic             load_d;
    logic [7:0]       load_val_q;
    logic [7:0]       load_val_d;

    assign raw = {sw_mode, btn_stop, btn_speedrun, btn_run, btn_next};

    // Two-flop synchronizers for the buttons, mode switch and value bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            val_meta_q <= '0;
            val_sync_q <= '0;
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            val_meta_q <= sw_value;
            val_sync_q <= val_meta_q;
        end
    end

    // Debounce: a lane flips only after DEB_CYCLES consecutive samples disagreeing with its level.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_TC) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Debounced levels, their run-length counters and the edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q  <= '0;
            prev_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q  <= deb_d;
            prev_q <= deb_q;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One-cycle request pulses on rising edges of the debounced levels.
    assign req = deb_q & ~prev_q;

    // Run-state register, divider and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            adv_q      <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            adv_q      <= adv_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
        end
    end

    // Next state in priority stop/halt > fast > run > hold; the divider runs only while holding RUN/FAST.
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        div_tc     = (state_q == ST_FAST) ? FAST_TC : SLOW_TC;
        tick       = 1'b0;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        adv_d      = 1'b0;

        if (req[I_STOP] || halt) begin
            state_d = ST_IDLE;
        end else if (req[I_FAST]) begin
            state_d = ST_FAST;
        end else if (req[I_RUN]) begin
            state_d = ST_RUN;
        end else if (state_q != ST_IDLE) begin
            if (div_q == div_tc) begin
                tick = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        // Load takes precedence over adv, and load mode silences adv entirely.
        load_d = req[I_MODE] | (req[I_NEXT] & deb_q[I_MODE]);
        if (load_d) begin
            load_val_d = val_sync_q;
        end
        adv_d = (tick | (req[I_NEXT] & (state_q == ST_IDLE))) & ~deb_q[I_MODE] & ~load_d;
    end

    assign adv       = adv_q;
    assign load      = load_q;
    assign load_val  = load_val_q;
    assign run_state = state_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with small timing parameters.
// Latency: checks outputs every cycle on the falling edge against a behavioural model.
// Backpressure: not applicable; halt is driven as a directed and random level.
module tb_counter_ctrl;

    localparam int DEB  = 4;
    localparam int SLOW = 10;
    localparam int FAST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_speedrun = 1'b0;
    logic       btn_stop = 1'b0;
    logic       sw_mode = 1'b0;
    logic [7:0] sw_value = 8'h00;
    logic       halt = 1'b0;
    logic       adv;
    logic       load;
    logic [7:0] load_val;
    logic [1:0] run_state;
    logic       busy;

    counter_ctrl #(
        .DEB_CYCLES (DEB),
        .SLOW_DIV   (SLOW),
        .FAST_DIV   (FAST),
        .DIV_W      (26)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_next     (btn_next),
        .btn_run      (btn_run),
        .btn_speedrun (btn_speedrun),
        .btn_stop     (btn_stop),
        .sw_mode      (sw_mode),
        .sw_value     (sw_value),
        .halt         (halt),
        .adv          (adv),
        .load         (load),
        .load_val     (load_val),
        .run_state    (run_state),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: lanes 0..4 = next, run, fast, stop, mode.
    bit         m_s1 [5];
    bit         m_s2 [5];
    bit         m_lvl [5];
    bit         m_prev [5];
    bit         m_hist [5][DEB];
    logic [7:0] m_v1, m_v2;
    int         m_state;
    int         m_phase;
    bit         m_adv, m_load;
    logic [7:0] m_lval;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
            for (int j = 0; j < DEB; j++) m_hist[i][j] = 0;
        end
        m_v1 = 0; m_v2 = 0; m_state = 0; m_phase = 0;
        m_adv = 0; m_load = 0; m_lval = 0;
    endtask

    task automatic model_step();
        bit raw [5];
        bit lvl_old [5];
        bit req [5];
        bit same, mode, tick, load_new, adv_new;
        int ns;
        raw[0] = btn_next; raw[1] = btn_run; raw[2] = btn_speedrun;
        raw[3] = btn_stop; raw[4] = sw_mode;
        for (int i = 0; i < 5; i++) begin
            lvl_old[i] = m_lvl[i];
            req[i] = m_lvl[i] && !m_prev[i];
            m_prev[i] = m_lvl[i];
            // Window of the last DEB synchronized samples; a unanimous, different window moves the level.
            for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s2[i];
            same = 1;
            for (int j = 1; j < DEB; j++) if (m_hist[i][j] != m_hist[i][0]) same = 0;
            if (same && m_hist[i][0] != m_lvl[i]) m_lvl[i] = m_hist[i][0];
        end
        mode = lvl_old[4];
        load_new = req[4] || (req[0] && mode);
        tick = 0;
        ns = m_state;
        if (req[3] || halt === 1'b1) begin
            ns = 0; m_phase = 0;
        end else if (req[2]) begin
            ns = 2; m_phase = 0;
        end else if (req[1]) begin
            ns = 1; m_phase = 0;
        end else if (m_state != 0) begin
            m_phase++;
            tick = (m_phase % ((m_state == 1) ? SLOW : FAST)) == 0;
        end
        adv_new = (tick || (req[0] && m_state == 0)) && !mode && !load_new;
        if (load_new) m_lval = m_v2;
        m_state = ns;
        m_adv = adv_new;
        m_load = load_new;
        for (int i = 0; i < 5; i++) begin
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        m_v2 = m_v1;
        m_v1 = sw_value;
    endtask

    int         cyc = 0;
    int         adv_cnt = 0;
    int         load_cnt = 0;
    int         last_adv_cyc = 0;
    int         last_iv = 0;
    logic [7:0] last_lv = 8'h00;

    task automatic tick_cycle();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        @(negedge clk);
        cyc++;
        check_eq("adv", {31'd0, adv}, {31'd0, m_adv});
        check_eq("load", {31'd0, load}, {31'd0, m_load});
        check_eq("load_val", {24'd0, load_val}, {24'd0, m_lval});
        check_eq("run_state", {30'd0, run_state}, m_state);
        check_eq("busy", {31'd0, busy}, {31'd0, (m_state != 0)});
        if (adv === 1'b1) begin
            adv_cnt++;
            last_iv = cyc - last_adv_cyc;
            last_adv_cyc = cyc;
        end
        if (load === 1'b1) begin
            load_cnt++;
            last_lv = load_val;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic set_in(input int which, input logic v);
        case (which)
            0: btn_next = v;
            1: btn_run = v;
            2: btn_speedrun = v;
            3: btn_stop = v;
            default: sw_mode = v;
        endcase
    endtask

    task automatic press(input int which, input int n);
        set_in(which, 1'b1);
        run(n);
        set_in(which, 1'b0);
    endtask

    initial begin
        bit seen;
        int d;
        int hold_left [6];
        model_reset();
        #2 rst = 1'b0;
        btn_next = 1; btn_run = 1; btn_speedrun = 1; btn_stop = 1;
        run(5);
        check_eq("rst_adv", {31'd0, adv}, 0);
        check_eq("rst_load", {31'd0, load}, 0);
        check_eq("rst_state", {30'd0, run_state}, 0);
        rst = 1'b1;
        btn_next = 0; btn_run = 0; btn_speedrun = 0; btn_stop = 0;
        run(20);
        check_eq("idle_no_adv", adv_cnt, 0);
        check_eq("idle_no_load", load_cnt, 0);

        // Glitch shorter than the debounce window, then a real press.
        press(0, 3);
        run(15);
        check_eq("glitch_no_adv", adv_cnt, 0);
        btn_next = 1;
        seen = 0; d = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick_cycle();
            d++;
            if (adv === 1'b1) seen = 1;
        end
        check_eq("step_latency", d, 2 + DEB + 1);
        run(59);
        btn_next = 0;
        run(15);
        check_eq("step_single", adv_cnt, 1);

        // RUN then FAST cadence, then stop.
        press(1, 8);
        run(45);
        check_eq("run_state1", {30'd0, run_state}, 1);
        check_eq("run_interval", last_iv, SLOW);
        press(2, 8);
        run(20);
        check_eq("fast_state2", {30'd0, run_state}, 2);
        check_eq("fast_interval", last_iv, FAST);
        press(3, 8);
        run(10);
        adv_cnt = 0;
        run(30);
        check_eq("stop_state0", {30'd0, run_state}, 0);
        check_eq("stop_no_adv", adv_cnt, 0);

        // Halt from FAST, and run requests ignored while halted.
        press(2, 8);
        run(15);
        halt = 1;
        tick_cycle();
        halt = 0;
        check_eq("halt_idle", {30'd0, run_state}, 0);
        halt = 1;
        press(1, 10);
        run(10);
        check_eq("halt_blocks_run", {30'd0, run_state}, 0);
        halt = 0;
        run(5);
        check_eq("halt_after", {30'd0, run_state}, 0);

        // Load mode.
        sw_value = 8'hA5;
        run(5);
        sw_mode = 1;
        run(15);
        check_eq("load_once", load_cnt, 1);
        check_eq("load_val_a5", {24'd0, last_lv}, 32'hA5);
        adv_cnt = 0;
        press(0, 8);
        run(10);
        check_eq("load_next", load_cnt, 2);
        check_eq("load_next_no_adv", adv_cnt, 0);
        press(1, 8);
        run(2);
        adv_cnt = 0;
        run(40);
        check_eq("mode_run_state", {30'd0, run_state}, 1);
        check_eq("mode_no_adv", adv_cnt, 0);
        sw_mode = 0;
        run(10);

        // Reset mid-run with the divider at its terminal value.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick_cycle();
            if (adv === 1'b1) seen = 1;
        end
        check_eq("midrun_adv_seen", {31'd0, seen}, 1);
        run(SLOW - 1);
        check_eq("midrun_state", {30'd0, run_state}, 1);
        rst = 1'b0;
        #1;
        check_eq("midrun_adv", {31'd0, adv}, 0);
        check_eq("midrun_state0", {30'd0, run_state}, 0);
        check_eq("midrun_busy", {31'd0, busy}, 0);
        model_reset();
        run(3);
        rst = 1'b1;
        run(5);

        // Randomized traffic on all inputs.
        for (int i = 0; i < 6; i++) hold_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_left[b] == 0) begin
                    if (b == 3) set_in(b, ($urandom_range(0, 3) == 0));
                    else set_in(b, $urandom_range(0, 1) == 1);
                    hold_left[b] = $urandom_range(1, 10);
                end else begin
                    hold_left[b]--;
                end
            end
            if (hold_left[4] == 0) begin
                sw_mode = ($urandom_range(0, 2) == 0);
                hold_left[4] = $urandom_range(20, 150);
            end else begin
                hold_left[4]--;
            end
            halt = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 7) == 0) sw_value = 8'($urandom_range(0, 255));
            tick_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
